// File: rtl/sd_zbus_pkg.sv
// rtl/sd_zbus_pkg.sv - shared types and constants for the z-bus master
package sd_zbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_RESP
    } state_t;

    localparam logic REQ_RD = 1'b0;
    localparam logic REQ_WR = 1'b1;

endpackage

// File: rtl/sd_zbus_master.sv
// rtl/sd_zbus_master.sv - single-outstanding request/response to z-bus strobe master with timeout
module sd_zbus_master
    import sd_zbus_pkg::*;
#(
    parameter int z_asz   = 16,
    parameter int timeout = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c_srdy,
    output logic             c_drdy,
    input  logic             c_req_type,
    input  logic [z_asz-1:0] c_addr,
    input  logic [7:0]       c_data,
    output logic             p_srdy,
    input  logic             p_drdy,
    output logic [7:0]       p_data,
    output logic             p_err,
    output logic [z_asz-1:0] addr,
    output logic [7:0]       wr_data,
    output logic             cs_n,
    output logic             mreq_n,
    output logic             rd_n,
    output logic             wr_n,
    input  logic             ack,
    input  logic [7:0]       rd_data
);

    localparam int CNT_W = (timeout > 0) ? $clog2(timeout + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(timeout);

    state_t           state;
    logic [CNT_W-1:0] strobe_cnt;
    logic             req_type;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            strobe_cnt <= '0;
            req_type   <= REQ_RD;
            c_drdy     <= 1'b0;
            p_srdy     <= 1'b0;
            p_err      <= 1'b0;
            p_data     <= 8'h00;
            addr       <= '0;
            wr_data    <= 8'h00;
            cs_n       <= 1'b1;
            mreq_n     <= 1'b1;
            rd_n       <= 1'b1;
            wr_n       <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    c_drdy <= 1'b1;
                    if (c_srdy && c_drdy) begin
                        addr     <= c_addr;
                        wr_data  <= c_data;
                        req_type <= c_req_type;
                        c_drdy   <= 1'b0;
                        cs_n     <= 1'b0;
                        mreq_n   <= 1'b0;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    strobe_cnt <= '0;
                    rd_n       <= (req_type != REQ_RD);
                    wr_n       <= (req_type != REQ_WR);
                    state      <= ST_STROBE;
                end
                ST_STROBE: begin
                    // ack takes priority over an expiring counter on the same cycle
                    if (ack || (strobe_cnt == CNT_MAX)) begin
                        if (ack) begin
                            p_data <= (req_type == REQ_RD) ? rd_data : 8'h00;
                            p_err  <= 1'b0;
                        end else begin
                            p_data <= 8'hFF;
                            p_err  <= 1'b1;
                        end
                        cs_n   <= 1'b1;
                        mreq_n <= 1'b1;
                        rd_n   <= 1'b1;
                        wr_n   <= 1'b1;
                        p_srdy <= 1'b1;
                        state  <= ST_RESP;
                    end else begin
                        strobe_cnt <= strobe_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (p_drdy) begin
                        p_srdy <= 1'b0;
                        c_drdy <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_zbus_master.sv
// tb/tb_sd_zbus_master.sv - scoreboard bench for sd_zbus_master with a behavioral memory slave
module tb_sd_zbus_master;
    import sd_zbus_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_srdy;
    logic        c_drdy;
    logic        c_req_type;
    logic [15:0] c_addr;
    logic [7:0]  c_data;
    logic        p_srdy;
    logic        p_drdy;
    logic [7:0]  p_data;
    logic        p_err;
    logic [15:0] addr;
    logic [7:0]  wr_data;
    logic        cs_n, mreq_n, rd_n, wr_n;
    logic        ack;
    logic [7:0]  rd_data;

    sd_zbus_master #(.z_asz(16), .timeout(4)) dut (
        .clk(clk), .reset(reset),
        .c_srdy(c_srdy), .c_drdy(c_drdy), .c_req_type(c_req_type),
        .c_addr(c_addr), .c_data(c_data),
        .p_srdy(p_srdy), .p_drdy(p_drdy), .p_data(p_data), .p_err(p_err),
        .addr(addr), .wr_data(wr_data),
        .cs_n(cs_n), .mreq_n(mreq_n), .rd_n(rd_n), .wr_n(wr_n),
        .ack(ack), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // Memory slave: acks on the (ack_wait+1)th active strobe cycle
    logic [7:0] mem [0:65535];
    int         ack_wait = 0;
    int         wcnt = 0;
    logic       slave_active;
    assign slave_active = !cs_n && !mreq_n && (!rd_n || !wr_n);
    assign ack          = slave_active && (wcnt == ack_wait);
    assign rd_data      = mem[addr];

    always @(posedge clk) begin
        if (!slave_active) wcnt <= 0;
        else               wcnt <= wcnt + 1;
        if (ack && !wr_n) mem[addr] <= wr_data;
    end

    typedef struct {
        logic [7:0] data;
        logic       err;
    } resp_t;

    resp_t exp_q[$];
    resp_t exp_r;
    int    errors = 0;
    int    checks = 0;
    int    rd_low = 0;
    int    wr_low = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (!rd_n) rd_low++;
            if (!wr_n) wr_low++;
            if ((!rd_n || !wr_n) && (cs_n || mreq_n)) begin
                checks++;
                errors++;
                $display("FAIL strobe_framing: rd_n/wr_n low with cs_n=%0b mreq_n=%0b", cs_n, mreq_n);
            end
            if (p_srdy && p_drdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp: got data=%0h err=%0b expected no response", p_data, p_err);
                end else begin
                    exp_r = exp_q.pop_front();
                    if (p_data !== exp_r.data || p_err !== exp_r.err) begin
                        errors++;
                        $display("FAIL resp: got data=%0h err=%0b expected data=%0h err=%0b",
                                 p_data, p_err, exp_r.data, exp_r.err);
                    end
                end
            end
        end
    end

    task automatic do_req(input string name, input logic t, input logic [15:0] a, input logic [7:0] d,
                          input int wait_n, input logic [7:0] ed, input logic ee,
                          input int elat, input int erd, input int ewr, input int hold);
        int lat;
        int guard;
        logic [7:0] d0;
        ack_wait = wait_n;
        @(negedge clk);
        p_drdy     = (hold == 0);
        c_srdy     = 1'b1;
        c_req_type = t;
        c_addr     = a;
        c_data     = d;
        guard = 0;
        while (!c_drdy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!c_drdy) begin
            chk({name, "_accept"}, 32'(c_drdy), 32'd1);
            c_srdy = 1'b0;
            p_drdy = 1'b1;
            return;
        end
        rd_low = 0;
        wr_low = 0;
        exp_q.push_back('{data: ed, err: ee});
        @(posedge clk);
        #1 c_srdy = 1'b0;
        lat = 0;
        while (!p_srdy && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'(elat));
        if (hold > 0) begin
            d0 = p_data;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                chk({name, "_bp_srdy"}, 32'(p_srdy), 32'd1);
                chk({name, "_bp_data"}, 32'(p_data), 32'(d0));
                chk({name, "_bp_cdrdy"}, 32'(c_drdy), 32'd0);
                chk({name, "_bp_strobes"}, 32'({cs_n, mreq_n, rd_n, wr_n}), 32'hF);
            end
            p_drdy = 1'b1;
        end
        guard = 0;
        while (p_srdy && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk({name, "_resp_done"}, 32'(p_srdy), 32'd0);
        chk({name, "_rd_low_cycles"}, 32'(rd_low), 32'(erd));
        chk({name, "_wr_low_cycles"}, 32'(wr_low), 32'(ewr));
    endtask

    initial begin
        int guard;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0010] = 8'h5A;
        mem[16'h0030] = 8'hA7;
        reset      = 1'b1;
        c_srdy     = 1'b0;
        c_req_type = REQ_RD;
        c_addr     = 16'h0000;
        c_data     = 8'h00;
        p_drdy     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_strobes", 32'({cs_n, mreq_n, rd_n, wr_n}), 32'hF);
        chk("rst_c_drdy", 32'(c_drdy), 32'd0);
        chk("rst_p_srdy", 32'(p_srdy), 32'd0);
        chk("rst_p_err", 32'(p_err), 32'd0);
        chk("rst_p_data", 32'(p_data), 32'h00);
        chk("rst_addr", 32'(addr), 32'h0000);
        chk("rst_wr_data", 32'(wr_data), 32'h00);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1 chk("post_rst_c_drdy", 32'(c_drdy), 32'd1);

        //      name        type    addr      data   wait ed     ee   lat rd wr hold
        do_req("rd_5a",     REQ_RD, 16'h0010, 8'h00, 0,   8'h5A, 1'b0, 2, 1, 0, 0);
        do_req("wr_c3",     REQ_WR, 16'h1FFF, 8'hC3, 0,   8'h00, 1'b0, 2, 0, 1, 0);
        chk("mem_1fff", 32'(mem[16'h1FFF]), 32'hC3);
        do_req("rd_c3",     REQ_RD, 16'h1FFF, 8'h00, 0,   8'hC3, 1'b0, 2, 1, 0, 0);
        do_req("rd_wait2",  REQ_RD, 16'h0010, 8'h00, 2,   8'h5A, 1'b0, 4, 3, 0, 0);
        do_req("rd_tmo",    REQ_RD, 16'h0020, 8'h00, 999, 8'hFF, 1'b1, 6, 5, 0, 0);
        do_req("rd_edge",   REQ_RD, 16'h0030, 8'h00, 4,   8'hA7, 1'b0, 6, 5, 0, 0);
        do_req("wr_tmo",    REQ_WR, 16'h0050, 8'h11, 999, 8'hFF, 1'b1, 6, 0, 5, 0);
        chk("mem_0050", 32'(mem[16'h0050]), 32'h00);
        do_req("rd_bp",     REQ_RD, 16'h0010, 8'h00, 0,   8'h5A, 1'b0, 2, 1, 0, 10);

        ack_wait = 999;
        @(negedge clk);
        c_srdy     = 1'b1;
        c_req_type = REQ_RD;
        c_addr     = 16'h0040;
        guard = 0;
        while (!c_drdy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 c_srdy = 1'b0;
        guard = 0;
        while (rd_n && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("rst_mid_rd_low", 32'(rd_n), 32'd0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_strobes", 32'({cs_n, mreq_n, rd_n, wr_n}), 32'hF);
        chk("rst_mid_p_srdy", 32'(p_srdy), 32'd0);
        chk("rst_mid_c_drdy", 32'(c_drdy), 32'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1 chk("rst_mid_c_drdy_after", 32'(c_drdy), 32'd1);
        repeat (3) @(posedge clk);
        #1 chk("rst_mid_no_resp", 32'(p_srdy), 32'd0);

        do_req("rd_after_rst", REQ_RD, 16'h1FFF, 8'h00, 0, 8'hC3, 1'b0, 2, 1, 0, 0);

        repeat (3) @(posedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/sd_zbus_master.md
SD_ZBUS_MASTER -- requirements
Module: sd_zbus_master

Interface
REQ-001 Parameters SHALL be: z_asz, default 16, bus address width; timeout, default 255, maximum strobe cycles allowed before a request is aborted.
REQ-002 clk  input  1  sole clock; all logic SHALL be rising-edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 c_srdy  input  1  request valid.
REQ-005 c_drdy  output  1  request accepted.
REQ-006 c_req_type  input  1  request type: 0 = read, 1 = write.
REQ-007 c_addr  input  z_asz  request address.
REQ-008 c_data  input  8  write data.
REQ-009 p_srdy  output  1  response valid.
REQ-010 p_drdy  input  1  response accepted.
REQ-011 p_data  output  8  read data; 8'h00 for writes; 8'hFF on timeout.
REQ-012 p_err  output  1  response is a timeout abort.
REQ-013 addr  output  z_asz  bus address.
REQ-014 wr_data  output  8  bus write data.
REQ-015 cs_n, mreq_n, rd_n, wr_n  output  1 each  active-low bus strobes.
REQ-016 ack  input  1  slave cycle complete.
REQ-017 rd_data  input  8  slave read data.

Function
REQ-018 A four-state FSM SHALL be used: IDLE, SETUP, STROBE, RESP.
REQ-019 c_drdy SHALL be 1 only in IDLE; a transfer occurs when c_srdy and c_drdy are both 1, and the FSM SHALL then move to SETUP.
REQ-020 On acceptance, c_addr, c_data and c_req_type SHALL be registered; addr and wr_data SHALL hold those values until the FSM returns to IDLE.
REQ-021 SETUP SHALL last exactly one cycle with cs_n=0 and mreq_n=0, rd_n=1 and wr_n=1; the FSM SHALL then move to STROBE.
REQ-022 In STROBE, cs_n and mreq_n SHALL be 0, and exactly one of rd_n or wr_n (matching the request type) SHALL be 0.
REQ-023 ack SHALL be ignored outside STROBE.
REQ-024 When ack=1 in STROBE: rd_data SHALL be captured (reads only), p_err SHALL be set to 0, and the FSM SHALL move to RESP.
REQ-025 A strobe-cycle counter SHALL clear on entry to STROBE and increment on each STROBE cycle with ack=0.
REQ-026 When the counter equals timeout with ack=0, the FSM SHALL move to RESP with p_err=1 and p_data=8'hFF.
REQ-027 If ack=1 on the same cycle the counter equals timeout, ack SHALL win and the response SHALL be normal (p_err=0).
REQ-028 The counter width SHALL be $clog2(timeout+1) and SHALL never wrap.
REQ-029 In RESP, all four strobes SHALL be 1 and p_srdy SHALL be 1; p_data and p_err SHALL be stable until p_drdy=1.
REQ-030 When p_drdy=1 in RESP, the FSM SHALL move to IDLE; a new request SHALL NOT be accepted in that same cycle.
REQ-031 Minimum request-to-response latency SHALL be: acceptance at cycle 0, SETUP at cycle 1, STROBE with ack at cycle 2, p_srdy=1 at cycle 3.
REQ-032 Every accepted request SHALL produce exactly one response; at most one request SHALL be outstanding.

Reset
REQ-033 While reset=1 at a clock edge, the FSM SHALL go to IDLE and the counter SHALL clear.
REQ-034 Reset values SHALL be: cs_n=mreq_n=rd_n=wr_n=1, p_srdy=0, p_err=0, p_data=0, addr=0, wr_data=0, c_drdy=0.
REQ-035 c_drdy SHALL go to 1 on the first cycle after reset deasserts.
REQ-036 A reset during any bus cycle SHALL release all strobes at the next edge and SHALL discard the in-flight response.

Structure
REQ-037 Package sd_zbus_pkg SHALL hold the state enumeration and the request-type constants (REQ_RD=0, REQ_WR=1).
REQ-038 The block SHALL be flat RTL, with no sub-module.
REQ-039 The bus port names and polarities SHALL match those consumed by sd_access64, so that sd_zbus_master connects directly to the memory slave.

Verification
REQ-040 Read, paired with the memory slave: preload 8'h5A at 16'h0010, issue a read of 16'h0010 -> p_data=8'h5A, p_err=0, rd_n low in STROBE only, wr_n never low.
REQ-041 Write then read: write 8'hC3 to 16'h1FFF, then read 16'h1FFF -> write response p_data=8'h00 with p_err=0; read response p_data=8'hC3.
REQ-042 Timeout: timeout=4 with ack held at 0 -> exactly 5 STROBE cycles, then p_srdy=1, p_err=1, p_data=8'hFF, strobes high.
REQ-043 Backpressure: hold p_drdy=0 for 10 cycles after a response -> p_srdy stays 1, p_data stable, c_drdy stays 0, strobes stay high.
REQ-044 Reset mid-STROBE: assert reset for 1 cycle while rd_n=0 -> strobes high at the next edge, no response is issued, c_drdy=1 on the first cycle after reset.
REQ-045 Boundary: ack=1 on the same cycle the counter reaches timeout -> p_err=0 and the captured rd_data is returned.
